// File: rtl/axi_mem_pkg.sv
// Shared types and widths for the AXI-style memory responder.
// ADDR_WIDTH/DATA_WIDTH normally come from mips_core.svh; fall back to 32 bits when standalone.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package axi_mem_pkg;
    localparam int ADDR_W    = `ADDR_WIDTH;
    localparam int DATA_W    = `DATA_WIDTH;
    localparam int AXI_ID_W  = 4;
    localparam int AXI_LEN_W = 4;

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_BURST
    } r_state_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } w_state_t;
endpackage

// File: rtl/axi_mem_responder_if.sv
// AW/W/B and AR/R channel bundle; the responder sits on the slave modport.
interface axi_mem_responder_if;
    import axi_mem_pkg::*;

    logic                 AWREADY;
    logic                 AWVALID;
    logic [AXI_ID_W-1:0]  AWID;
    logic [AXI_LEN_W-1:0] AWLEN;
    logic [ADDR_W-1:0]    AWADDR;

    logic                 WREADY;
    logic                 WVALID;
    logic                 WLAST;
    logic [AXI_ID_W-1:0]  WID;
    logic [DATA_W-1:0]    WDATA;

    logic                 BREADY;
    logic                 BVALID;
    logic [AXI_ID_W-1:0]  BID;

    logic                 ARREADY;
    logic                 ARVALID;
    logic [AXI_ID_W-1:0]  ARID;
    logic [AXI_LEN_W-1:0] ARLEN;
    logic [ADDR_W-1:0]    ARADDR;

    logic                 RREADY;
    logic                 RVALID;
    logic                 RLAST;
    logic [AXI_ID_W-1:0]  RID;
    logic [DATA_W-1:0]    RDATA;

    modport slave (
        output AWREADY, input AWVALID, AWID, AWLEN, AWADDR,
        output WREADY,  input WVALID, WLAST, WID, WDATA,
        input  BREADY,  output BVALID, BID,
        output ARREADY, input ARVALID, ARID, ARLEN, ARADDR,
        input  RREADY,  output RVALID, RLAST, RID, RDATA
    );

    modport master (
        input  AWREADY, output AWVALID, AWID, AWLEN, AWADDR,
        input  WREADY,  output WVALID, WLAST, WID, WDATA,
        output BREADY,  input BVALID, BID,
        input  ARREADY, output ARVALID, ARID, ARLEN, ARADDR,
        output RREADY,  input RVALID, RLAST, RID, RDATA
    );
endinterface

// File: rtl/axi_mem_array.sv
// Word array with one synchronous write port and one asynchronous read port.
// A read of the word being written in the same cycle returns the old contents.
module axi_mem_array #(
    parameter int MEM_WORDS = 65536,
    parameter int DATA_W    = 32
) (
    input  logic                         clk,
    input  logic                         we,
    input  logic [$clog2(MEM_WORDS)-1:0] waddr,
    input  logic [DATA_W-1:0]            wdata,
    input  logic [$clog2(MEM_WORDS)-1:0] raddr,
    output logic [DATA_W-1:0]            rdata
);
    logic [DATA_W-1:0] mem_q [MEM_WORDS];

    // NOTE: the array has no reset, so contents survive rst_n and the storage maps onto RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/axi_mem_responder.sv
// AXI-style memory responder: independent one-burst-at-a-time read and write engines
// over a shared word array; reads return data after READ_LATENCY idle cycles.
module axi_mem_responder
    import axi_mem_pkg::*;
#(
    parameter int MEM_WORDS    = 65536,
    parameter int READ_LATENCY = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    axi_mem_responder_if.slave       bus,
    output logic                     proto_err
);
    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam logic [3:0] LAT_LOAD = 4'((READ_LATENCY > 0) ? READ_LATENCY - 1 : 0);

    typedef logic [IDX_W-1:0]     idx_t;
    typedef logic [AXI_LEN_W-1:0] len_t;
    typedef logic [AXI_ID_W-1:0]  id_t;

    r_state_t r_state_q, r_state_d;
    idx_t     r_idx_q, r_idx_d;
    len_t     r_beat_q, r_beat_d;
    len_t     r_len_q, r_len_d;
    id_t      r_id_q, r_id_d;
    logic [3:0] r_cnt_q, r_cnt_d;
    logic     arready_q, arready_d;

    w_state_t w_state_q, w_state_d;
    idx_t     w_idx_q, w_idx_d;
    len_t     w_beat_q, w_beat_d;
    len_t     w_len_q, w_len_d;
    id_t      w_id_q, w_id_d;
    logic     awready_q, awready_d;
    logic     err_q, err_d;
    logic     w_we;

    logic [DATA_W-1:0] rd_word;
    logic              unused_addr;

    axi_mem_array #(
        .MEM_WORDS (MEM_WORDS),
        .DATA_W    (DATA_W)
    ) u_array (
        .clk   (clk),
        .we    (w_we),
        .waddr (w_idx_q),
        .wdata (bus.WDATA),
        .raddr (r_idx_q),
        .rdata (rd_word)
    );

    // READY is held low for one idle cycle after each burst (turnaround bubble, and after reset).
    always_comb begin
        // NOTE: every _d gets its default first so no path leaves it unassigned (no latches).
        r_state_d = r_state_q;
        r_idx_d   = r_idx_q;
        r_beat_d  = r_beat_q;
        r_len_d   = r_len_q;
        r_id_d    = r_id_q;
        r_cnt_d   = r_cnt_q;
        arready_d = 1'b0;
        unique case (r_state_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (bus.ARVALID && arready_q) begin
                    arready_d = 1'b0;
                    r_idx_d   = bus.ARADDR[IDX_W+1:2];
                    r_len_d   = bus.ARLEN;
                    r_id_d    = bus.ARID;
                    r_beat_d  = '0;
                    r_cnt_d   = LAT_LOAD;
                    r_state_d = (READ_LATENCY == 0) ? R_BURST : R_WAIT;
                end
            end
            R_WAIT: begin
                if (r_cnt_q == 4'd0) r_state_d = R_BURST;
                else                 r_cnt_d   = r_cnt_q - 4'd1;
            end
            R_BURST: begin
                if (bus.RREADY) begin
                    r_idx_d  = r_idx_q + idx_t'(1);
                    r_beat_d = r_beat_q + len_t'(1);
                    if (r_beat_q == r_len_q) r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        w_state_d = w_state_q;
        w_idx_d   = w_idx_q;
        w_beat_d  = w_beat_q;
        w_len_d   = w_len_q;
        w_id_d    = w_id_q;
        awready_d = 1'b0;
        err_d     = err_q;
        w_we      = 1'b0;
        unique case (w_state_q)
            W_IDLE: begin
                awready_d = 1'b1;
                if (bus.WVALID) err_d = 1'b1;
                if (bus.AWVALID && awready_q) begin
                    awready_d = 1'b0;
                    w_idx_d   = bus.AWADDR[IDX_W+1:2];
                    w_len_d   = bus.AWLEN;
                    w_id_d    = bus.AWID;
                    w_beat_d  = '0;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (bus.WVALID) begin
                    w_we     = 1'b1;
                    w_idx_d  = w_idx_q + idx_t'(1);
                    w_beat_d = w_beat_q + len_t'(1);
                    // Beat count comes from AWLEN; WLAST and WID are only policed.
                    if (bus.WLAST != (w_beat_q == w_len_q)) err_d = 1'b1;
                    if (bus.WID != w_id_q)                  err_d = 1'b1;
                    if (w_beat_q == w_len_q)                w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (bus.BREADY) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q <= R_IDLE;
            r_idx_q   <= '0;
            r_beat_q  <= '0;
            r_len_q   <= '0;
            r_id_q    <= '0;
            r_cnt_q   <= '0;
            arready_q <= 1'b0;
            w_state_q <= W_IDLE;
            w_idx_q   <= '0;
            w_beat_q  <= '0;
            w_len_q   <= '0;
            w_id_q    <= '0;
            awready_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            r_idx_q   <= r_idx_d;
            r_beat_q  <= r_beat_d;
            r_len_q   <= r_len_d;
            r_id_q    <= r_id_d;
            r_cnt_q   <= r_cnt_d;
            arready_q <= arready_d;
            w_state_q <= w_state_d;
            w_idx_q   <= w_idx_d;
            w_beat_q  <= w_beat_d;
            w_len_q   <= w_len_d;
            w_id_q    <= w_id_d;
            awready_q <= awready_d;
            err_q     <= err_d;
        end
    end

    assign bus.ARREADY = arready_q;
    assign bus.RVALID  = (r_state_q == R_BURST);
    assign bus.RLAST   = (r_state_q == R_BURST) && (r_beat_q == r_len_q);
    assign bus.RID     = r_id_q;
    assign bus.RDATA   = (r_state_q == R_BURST) ? rd_word : '0;

    assign bus.AWREADY = awready_q;
    assign bus.WREADY  = (w_state_q == W_DATA);
    assign bus.BVALID  = (w_state_q == W_RESP);
    assign bus.BID     = w_id_q;

    assign proto_err   = err_q;

    assign unused_addr = ^{bus.AWADDR, bus.ARADDR};
endmodule
